// File: rtl/mem_burst_ctrl_pkg.sv
// ============================================================================
// Module   : mem_burst_ctrl_pkg
// Brief    : Shared burst-controller types and SRAM geometry defaults.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_burst_ctrl_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_burst_ctrl_reg_slice.sv
// ============================================================================
// Module   : mem_burst_ctrl_reg_slice
// Brief    : One-entry holding register; a load wins over a same-cycle drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_burst_ctrl_reg_slice #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] d,
    output logic              full,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            q    <= '0;
        end else if (load) begin
            full <= 1'b1;
            q    <= d;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_burst_ctrl.sv
// ============================================================================
// Module   : mem_burst_ctrl
// Brief    : Burst front-end turning one command into per-word SRAM accesses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_burst_ctrl
    import mem_burst_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_SIZE = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_wr_rd_i,
    input  logic [ADDR_SIZE-1:0] cmd_addr_i,
    input  logic [ADDR_SIZE:0]   cmd_len_i,
    input  logic                 wdata_valid_i,
    output logic                 wdata_ready_o,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic                 rdata_valid_o,
    input  logic                 rdata_ready_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 rdata_last_o,
    output logic                 done_o,
    output logic                 mem_valid_o,
    output logic                 mem_wr_rd_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [WIDTH-1:0]     mem_wdata_o,
    input  logic                 mem_ready_i,
    input  logic [WIDTH-1:0]     mem_rdata_i
);

    localparam int                   c_cnt_w    = ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE-1:0] c_addr_one = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = {{(c_cnt_w-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_dir;
    logic                 r_done;
    logic                 r_cmd_ready;

    logic                 w_in_write;
    logic                 w_in_read;
    logic                 w_cmd_hs;
    logic                 w_rd_mem_ok;
    logic                 w_mem_valid;
    logic                 w_mem_hs;
    logic                 w_wdrain;
    logic                 w_wneed;
    logic                 w_wready;
    logic                 w_wload;
    logic                 w_rload;
    logic                 w_rdrain;
    logic                 w_last_fill;
    logic                 w_wfull;
    logic [WIDTH-1:0]     w_wq;
    logic                 w_rfull;
    logic [WIDTH:0]       w_rq;

    assign w_in_write  = (r_state == ST_WRITE);
    assign w_in_read   = (r_state == ST_READ);
    assign w_cmd_hs    = cmd_valid_i && r_cmd_ready;

    // Reads are only issued when the output register has room for the result.
    assign w_rd_mem_ok = w_in_read && (r_cnt != '0) && (!w_rfull || rdata_ready_i);
    assign w_mem_valid = (w_in_write && w_wfull) || w_rd_mem_ok;
    assign w_mem_hs    = w_mem_valid && mem_ready_i;

    // A new write word is needed only while words remain beyond the one held.
    assign w_wdrain    = w_in_write && w_mem_hs;
    assign w_wneed     = r_cnt > {{ADDR_SIZE{1'b0}}, w_wfull};
    assign w_wready    = w_in_write && (!w_wfull || w_wdrain) && w_wneed;
    assign w_wload     = w_wready && wdata_valid_i;

    assign w_rload     = w_in_read && w_mem_hs;
    assign w_rdrain    = w_rfull && rdata_ready_i;
    assign w_last_fill = (r_cnt == c_cnt_one);

    mem_burst_ctrl_reg_slice #(
        .DATA_W (WIDTH)
    ) u_wr_slice (
        .clk   (clk_i),
        .rst   (rst_i),
        .load  (w_wload),
        .drain (w_wdrain),
        .d     (wdata_i),
        .full  (w_wfull),
        .q     (w_wq)
    );

    mem_burst_ctrl_reg_slice #(
        .DATA_W (WIDTH + 1)
    ) u_rd_slice (
        .clk   (clk_i),
        .rst   (rst_i),
        .load  (w_rload),
        .drain (w_rdrain),
        .d     ({w_last_fill, mem_rdata_i}),
        .full  (w_rfull),
        .q     (w_rq)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_hs) begin
                        r_addr      <= cmd_addr_i;
                        r_cnt       <= cmd_len_i;
                        r_dir       <= cmd_wr_rd_i;
                        r_cmd_ready <= 1'b0;
                        if (cmd_len_i == '0) begin
                            r_state <= ST_DONE;
                        end else if (cmd_wr_rd_i) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_mem_hs) begin
                        r_addr <= r_addr + c_addr_one;
                        r_cnt  <= r_cnt - c_cnt_one;
                        if (w_last_fill) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (w_mem_hs) begin
                        r_addr <= r_addr + c_addr_one;
                        r_cnt  <= r_cnt - c_cnt_one;
                    end
                    if (w_rdrain && w_rq[WIDTH]) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // A zero-length burst arrives here with done low and pulses it one cycle later.
                    if (r_done) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign wdata_ready_o = w_wready;
    assign rdata_valid_o = w_rfull;
    assign rdata_o       = w_rq[WIDTH-1:0];
    assign rdata_last_o  = w_rq[WIDTH];
    assign done_o        = r_done;
    assign mem_valid_o   = w_mem_valid;
    assign mem_wr_rd_o   = r_dir;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = w_wq;

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
// ============================================================================
// Module   : tb_mem_burst_ctrl
// Brief    : Self-checking bench with an SRAM responder and a burst-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_burst_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_wr_rd;
    logic [AW-1:0]    cmd_addr;
    logic [AW:0]      cmd_len;
    logic             wdata_valid;
    logic             wdata_ready;
    logic [WIDTH-1:0] wdata;
    logic             rdata_valid;
    logic             rdata_ready;
    logic [WIDTH-1:0] rdata;
    logic             rdata_last;
    logic             done;
    logic             mem_valid;
    logic             mem_wr_rd;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;

    mem_burst_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_wr_rd_i   (cmd_wr_rd),
        .cmd_addr_i    (cmd_addr),
        .cmd_len_i     (cmd_len),
        .wdata_valid_i (wdata_valid),
        .wdata_ready_o (wdata_ready),
        .wdata_i       (wdata),
        .rdata_valid_o (rdata_valid),
        .rdata_ready_i (rdata_ready),
        .rdata_o       (rdata),
        .rdata_last_o  (rdata_last),
        .done_o        (done),
        .mem_valid_o   (mem_valid),
        .mem_wr_rd_o   (mem_wr_rd),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_ready_i   (mem_ready),
        .mem_rdata_i   (mem_rdata)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // SRAM responder state and observation logs
    logic [WIDTH-1:0] sram    [DEPTH];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] wwords  [DEPTH];
    int               wait_mode  = 0;
    int               wait_fixed = 0;
    int               stab_err   = 0;
    int               mv_count   = 0;
    int               acc_addr [$];
    logic [WIDTH-1:0] acc_data [$];
    bit               acc_wr   [$];
    int               acc_cyc  [$];
    logic [WIDTH-1:0] rd_data  [$];
    bit               rd_last  [$];
    int               rd_cyc   [$];

    int accept_cyc, first_take, done_cnt, done_cyc, mv_base;

    initial begin
        int               wcnt, cur_wait;
        bit               new_req, prev_stall;
        logic [AW-1:0]    p_addr;
        logic             p_wr;
        logic [WIDTH-1:0] p_wd;
        wcnt = 0; cur_wait = 0; new_req = 1'b1; prev_stall = 1'b0;
        p_addr = '0; p_wr = 1'b0; p_wd = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) sram[i] = '0;
        forever begin
            @(negedge clk);
            if (rst || mem_valid !== 1'b1) begin
                mem_ready = 1'b0;
                wcnt      = 0;
                new_req   = 1'b1;
            end else begin
                if (new_req) begin
                    cur_wait = (wait_mode == 0) ? 0 :
                               (wait_mode == 1) ? wait_fixed : int'($urandom_range(0, 3));
                    new_req  = 1'b0;
                end
                mem_ready = (wcnt >= cur_wait);
            end
            mem_rdata = mem_ready ? sram[mem_addr] : WIDTH'($urandom);
            #2;
            if (prev_stall && !rst &&
                (mem_valid !== 1'b1 || mem_addr !== p_addr || mem_wr_rd !== p_wr || mem_wdata !== p_wd))
                stab_err++;
            prev_stall = !rst && (mem_valid === 1'b1) && !mem_ready;
            p_addr = mem_addr; p_wr = mem_wr_rd; p_wd = mem_wdata;
            if (!rst && mem_valid === 1'b1 && mem_ready) begin
                acc_addr.push_back(int'(mem_addr));
                acc_data.push_back(mem_wdata);
                acc_wr.push_back(mem_wr_rd);
                acc_cyc.push_back(cyc);
                if (mem_wr_rd) sram[mem_addr] = mem_wdata;
                wcnt    = 0;
                new_req = 1'b1;
            end else if (mem_valid === 1'b1) begin
                wcnt++;
            end
            if (mem_valid === 1'b1) mv_count++;
        end
    end

    // Drives one burst: rdy_mode 0=always,1=toggle,2=random; wv_mode 0=always,1=random gaps.
    task automatic run_burst(input bit wr, input int addr, input int len,
                             input int rdy_mode, input int wv_mode, input int abort_after);
        int  widx = 0;
        bit  sent = 1'b0;
        int  post = 0;
        acc_addr.delete(); acc_data.delete(); acc_wr.delete(); acc_cyc.delete();
        rd_data.delete(); rd_last.delete(); rd_cyc.delete();
        accept_cyc = -1; first_take = -1; done_cnt = 0; done_cyc = -1; mv_base = mv_count;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            cmd_valid   = !sent;
            cmd_wr_rd   = wr;
            cmd_addr    = AW'(addr);
            cmd_len     = (AW+1)'(len);
            wdata_valid = wr && (widx < len) && (wv_mode == 0 || $urandom_range(0, 1) == 1);
            wdata       = wwords[widx % DEPTH];
            rdata_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? n[0] : 1'($urandom_range(0, 1));
            @(negedge clk); #3;
            if (cmd_valid && cmd_ready) begin sent = 1'b1; accept_cyc = cyc; end
            if (wdata_valid && wdata_ready) begin
                if (widx == 0) first_take = cyc;
                widx++;
            end
            if (rdata_valid && rdata_ready) begin
                rd_data.push_back(rdata); rd_last.push_back(rdata_last); rd_cyc.push_back(cyc);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (abort_after > 0 && acc_addr.size() >= abort_after) break;
            if (done_cnt > 0) post++;
            if (post >= 3) break;
        end
        cmd_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wdata_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cmd_ready, wdata_ready, rdata_valid, rdata_last, done, mem_valid, mem_wr_rd} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {cmd_ready, wdata_ready, rdata_valid, rdata_last, done, mem_valid, mem_wr_rd});
        end
        total++;
        if (mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%0d wdata=%h rdata=%h want all 0", mem_addr, mem_wdata, rdata);
        end
        wdata_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_basic();
        wait_mode = 0;
        for (int i = 0; i < 5; i++) wwords[i] = 16'h1111 * 16'(i + 1);
        run_burst(1'b1, 0, 5, 0, 0, 0);
        total++;
        if (acc_addr.size() != 5) begin bad++; $display("FAIL wr_basic_count: got %0d want 5", acc_addr.size()); end
        for (int i = 0; i < 5 && i < acc_addr.size(); i++) begin
            total++;
            if (acc_addr[i] != i || acc_data[i] !== wwords[i] || acc_wr[i] !== 1'b1 || acc_cyc[i] != acc_cyc[0] + i) begin
                bad++;
                $display("FAIL wr_basic_acc%0d: got addr=%0d data=%h wr=%b cyc=%0d want addr=%0d data=%h wr=1 cyc=%0d",
                         i, acc_addr[i], acc_data[i], acc_wr[i], acc_cyc[i], i, wwords[i], acc_cyc[0] + i);
            end
        end
        if (acc_cyc.size() == 5) begin
            total++;
            if (acc_cyc[0] != first_take + 1) begin
                bad++; $display("FAIL wr_first_latency: got cyc %0d want %0d", acc_cyc[0], first_take + 1);
            end
            total++;
            if (done_cnt != 1 || done_cyc != acc_cyc[4] + 1) begin
                bad++; $display("FAIL wr_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, acc_cyc[4] + 1);
            end
        end
        for (int i = 0; i < 5; i++) ref_mem[i] = wwords[i];
    endtask

    task automatic test_read_toggle();
        wait_mode = 0;
        for (int i = 0; i < 4; i++) wwords[i] = WIDTH'($urandom);
        run_burst(1'b1, 10, 4, 0, 1, 0);
        for (int i = 0; i < 4; i++) ref_mem[10 + i] = wwords[i];
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL rd_prefill_done: got %0d want 1", done_cnt); end
        run_burst(1'b0, 10, 4, 1, 0, 0);
        total++;
        if (rd_data.size() != 4) begin bad++; $display("FAIL rd_tog_count: got %0d want 4", rd_data.size()); end
        for (int i = 0; i < 4 && i < rd_data.size(); i++) begin
            total++;
            if (rd_data[i] !== ref_mem[10 + i] || rd_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL rd_tog_word%0d: got data=%h last=%b want data=%h last=%b",
                         i, rd_data[i], rd_last[i], ref_mem[10 + i], (i == 3));
            end
        end
        total++;
        if (acc_cyc.size() == 0 || acc_cyc[0] != accept_cyc + 1 || acc_wr[0] !== 1'b0) begin
            bad++; $display("FAIL rd_first_latency: got %0d accesses accept=%0d want first read at accept+1",
                            acc_cyc.size(), accept_cyc);
        end
        total++;
        if (rd_cyc.size() != 4 || done_cnt != 1 || done_cyc != rd_cyc[3] + 1) begin
            bad++; $display("FAIL rd_done: got cnt=%0d cyc=%0d want one pulse after last consumer handshake",
                            done_cnt, done_cyc);
        end
    endtask

    task automatic test_wrap();
        wait_mode = 0;
        for (int i = 0; i < 4; i++) wwords[i] = WIDTH'($urandom);
        run_burst(1'b1, 62, 4, 0, 0, 0);
        total++;
        if (acc_addr.size() != 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", acc_addr.size()); end
        for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
            total++;
            if (acc_addr[i] != (62 + i) % DEPTH || acc_data[i] !== wwords[i]) begin
                bad++; $display("FAIL wrap_acc%0d: got addr=%0d data=%h want addr=%0d data=%h",
                                i, acc_addr[i], acc_data[i], (62 + i) % DEPTH, wwords[i]);
            end
        end
        for (int i = 0; i < 4; i++) ref_mem[(62 + i) % DEPTH] = wwords[i];
    endtask

    task automatic test_zero_len();
        for (int d = 0; d < 2; d++) begin
            run_burst(d[0], int'($urandom_range(0, DEPTH - 1)), 0, 0, 0, 0);
            total++;
            if (mv_count != mv_base) begin bad++; $display("FAIL zero_len_mem_valid: got %0d cycles want 0", mv_count - mv_base); end
            total++;
            if (done_cnt != 1 || done_cyc != accept_cyc + 2) begin
                bad++; $display("FAIL zero_len_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, accept_cyc + 2);
            end
        end
    endtask

    task automatic test_wait_states();
        int a;
        a = int'($urandom_range(0, DEPTH - 1));
        wait_mode = 1; wait_fixed = 3; stab_err = 0;
        for (int i = 0; i < 6; i++) wwords[i] = WIDTH'($urandom);
        run_burst(1'b1, a, 6, 0, 0, 0);
        total++;
        if (acc_addr.size() != 6 || done_cnt != 1) begin
            bad++; $display("FAIL wait_wr_count: got acc=%0d done=%0d want acc=6 done=1", acc_addr.size(), done_cnt);
        end
        for (int i = 1; i < 6 && i < acc_cyc.size(); i++) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] != 4 || acc_addr[i] != (a + i) % DEPTH || acc_data[i] !== wwords[i]) begin
                bad++; $display("FAIL wait_wr_acc%0d: got gap=%0d addr=%0d data=%h want gap=4 addr=%0d data=%h",
                                i, acc_cyc[i] - acc_cyc[i-1], acc_addr[i], acc_data[i], (a + i) % DEPTH, wwords[i]);
            end
        end
        for (int i = 0; i < 6; i++) ref_mem[(a + i) % DEPTH] = wwords[i];
        run_burst(1'b0, a, 6, 2, 0, 0);
        total++;
        if (rd_data.size() != 6 || done_cnt != 1) begin
            bad++; $display("FAIL wait_rd_count: got rd=%0d done=%0d want rd=6 done=1", rd_data.size(), done_cnt);
        end
        for (int i = 0; i < rd_data.size() && i < 6; i++) begin
            total++;
            if (rd_data[i] !== ref_mem[(a + i) % DEPTH] || rd_last[i] !== (i == 5)) begin
                bad++; $display("FAIL wait_rd_word%0d: got data=%h last=%b want data=%h last=%b",
                                i, rd_data[i], rd_last[i], ref_mem[(a + i) % DEPTH], (i == 5));
            end
        end
        total++;
        if (stab_err != 0) begin bad++; $display("FAIL wait_stability: got %0d unstable stalls want 0", stab_err); end
        wait_mode = 0;
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        wait_mode = 0;
        for (int i = 0; i < 6; i++) wwords[i] = WIDTH'($urandom);
        run_burst(1'b1, 30, 6, 0, 0, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if ({cmd_ready, wdata_ready, rdata_valid, rdata_last, done, mem_valid, mem_wr_rd} !== 7'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
            bad++; $display("FAIL reset_mid_outputs: ctl=%b addr=%0d wdata=%h rdata=%h want all 0",
                            {cmd_ready, wdata_ready, rdata_valid, rdata_last, done, mem_valid, mem_wr_rd},
                            mem_addr, mem_wdata, rdata);
        end
        repeat (3) begin @(negedge clk); if (done) saw_done = 1'b1; end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(negedge clk); if (done) saw_done = 1'b1; end
        total++;
        if (saw_done) begin bad++; $display("FAIL reset_mid_no_done: got done pulse want none"); end
        ref_mem[30] = wwords[0];
        ref_mem[31] = wwords[1];
        run_burst(1'b0, 28, 6, 0, 0, 0);
        total++;
        if (rd_data.size() != 6 || done_cnt != 1) begin
            bad++; $display("FAIL reset_mid_read_count: got rd=%0d done=%0d want rd=6 done=1", rd_data.size(), done_cnt);
        end
        for (int i = 0; i < rd_data.size() && i < 6; i++) begin
            total++;
            if (rd_data[i] !== ref_mem[28 + i]) begin
                bad++; $display("FAIL reset_mid_read%0d: got %h want %h", i, rd_data[i], ref_mem[28 + i]);
            end
        end
    endtask

    task automatic test_random();
        bit wr;
        int a, len;
        wait_mode = 2; stab_err = 0;
        for (int k = 0; k < 12; k++) begin
            wr  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            a   = int'($urandom_range(0, DEPTH - 1));
            len = (k == 0) ? DEPTH : int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) wwords[i] = WIDTH'($urandom);
            run_burst(wr, a, len, 2, 1, 0);
            total++;
            if (done_cnt != 1) begin bad++; $display("FAIL rand%0d_done: got %0d want 1", k, done_cnt); end
            if (wr) begin
                total++;
                if (acc_addr.size() != len) begin bad++; $display("FAIL rand%0d_wcount: got %0d want %0d", k, acc_addr.size(), len); end
                for (int i = 0; i < len && i < acc_addr.size(); i++) begin
                    total++;
                    if (acc_addr[i] != (a + i) % DEPTH || acc_data[i] !== wwords[i] || acc_wr[i] !== 1'b1) begin
                        bad++; $display("FAIL rand%0d_wacc%0d: got addr=%0d data=%h want addr=%0d data=%h",
                                        k, i, acc_addr[i], acc_data[i], (a + i) % DEPTH, wwords[i]);
                    end
                end
                for (int i = 0; i < len; i++) ref_mem[(a + i) % DEPTH] = wwords[i];
            end else begin
                total++;
                if (rd_data.size() != len) begin bad++; $display("FAIL rand%0d_rcount: got %0d want %0d", k, rd_data.size(), len); end
                for (int i = 0; i < len && i < rd_data.size(); i++) begin
                    total++;
                    if (rd_data[i] !== ref_mem[(a + i) % DEPTH] || rd_last[i] !== (i == len - 1)) begin
                        bad++; $display("FAIL rand%0d_rword%0d: got data=%h last=%b want data=%h last=%b",
                                        k, i, rd_data[i], rd_last[i], ref_mem[(a + i) % DEPTH], (i == len - 1));
                    end
                end
            end
        end
        total++;
        if (stab_err != 0) begin bad++; $display("FAIL rand_stability: got %0d unstable stalls want 0", stab_err); end
        wait_mode = 0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_wr_rd = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; wwords[i] = '0; end
        test_reset();
        test_write_basic();
        test_read_toggle();
        test_wrap();
        test_zero_len();
        test_wait_states();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
